// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and the LSU.
// Only one transaction is ever outstanding; the LSU has priority, and a starvation guard protects fetch.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    input  logic        ls_we,
    input  logic [1:0]  ls_sz,
    input  logic        ls_sx,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    // state | meaning
    // IDLE  | arbitrate; also the response / error-response cycle
    // ADDR  | bus_req held with stable fields until bus_gnt
    // RESP  | waiting for bus_rvalid
    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    localparam int CW = $clog2(STARVE_MAX + 1);

    state_t          state;
    logic [CW-1:0]   starve_cnt;
    logic            err_pend;
    logic            owner_ls;
    logic [1:0]      r_sz;
    logic            r_sx;
    logic [1:0]      r_a;

    logic            can_accept;
    logic            starved;
    logic            fetch_win;
    logic [1:0]      ls_a;
    logic            ls_fault;
    logic [3:0]      ls_be;
    logic [31:0]     ls_wlane;
    logic [15:0]     rshift;
    logic [31:0]     ld_data;

    assign can_accept = (state == IDLE) && !err_pend && !rst;
    assign starved    = (starve_cnt == CW'(STARVE_MAX));
    assign fetch_win  = if_req && (!ls_req || starved);
    assign if_ready   = can_accept && fetch_win;
    assign ls_ready   = can_accept && ls_req && !fetch_win;
    assign ls_a       = ls_addr[1:0];

    always_comb begin
        ls_fault = 1'b0;
        ls_be    = 4'b1111;
        ls_wlane = ls_wdata;
        case (ls_sz)
            2'd0: begin
                ls_be    = 4'b0001 << ls_a;
                ls_wlane = {4{ls_wdata[7:0]}};
            end
            2'd1: begin
                ls_fault = ls_a[0];
                ls_be    = ls_a[1] ? 4'b1100 : 4'b0011;
                ls_wlane = {2{ls_wdata[15:0]}};
            end
            2'd2: ls_fault = (ls_a != 2'd0);
            default: ls_fault = 1'b1;
        endcase
    end

    // Only the low halfword of the shifted read is needed for sub-word loads.
    assign rshift = 16'(bus_rdata >> {r_a, 3'b000});

    always_comb begin
        ld_data = bus_rdata;
        case (r_sz)
            2'd0:    ld_data = {{24{r_sx & rshift[7]}}, rshift[7:0]};
            2'd1:    ld_data = {{16{r_sx & rshift[15]}}, rshift[15:0]};
            default: ld_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            err_pend   <= 1'b0;
            owner_ls   <= 1'b0;
            r_sz       <= 2'd0;
            r_sx       <= 1'b0;
            r_a        <= 2'd0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            ls_rvalid  <= 1'b0;
            ls_rdata   <= '0;
            ls_err     <= 1'b0;
            bus_req    <= 1'b0;
            bus_addr   <= '0;
            bus_we     <= 1'b0;
            bus_be     <= '0;
            bus_wdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            err_pend  <= 1'b0;

            if (if_ready || (state == IDLE && !if_req))
                starve_cnt <= '0;
            else if (ls_ready && !starved)
                starve_cnt <= starve_cnt + CW'(1);

            case (state)
                IDLE: begin
                    if (if_ready) begin
                        owner_ls  <= 1'b0;
                        bus_addr  <= if_addr & 32'hFFFF_FFFC;
                        bus_be    <= 4'b1111;
                        bus_we    <= 1'b0;
                        bus_wdata <= '0;
                        bus_req   <= 1'b1;
                        state     <= ADDR;
                    end else if (ls_ready) begin
                        if (ls_fault) begin
                            // Faulting accesses never reach the bus; answer next cycle.
                            err_pend  <= 1'b1;
                            ls_rvalid <= 1'b1;
                            ls_err    <= 1'b1;
                            ls_rdata  <= '0;
                        end else begin
                            owner_ls  <= 1'b1;
                            r_sz      <= ls_sz;
                            r_sx      <= ls_sx;
                            r_a       <= ls_a;
                            bus_addr  <= ls_addr & 32'hFFFF_FFFC;
                            bus_be    <= ls_be;
                            bus_we    <= ls_we;
                            bus_wdata <= ls_wlane;
                            bus_req   <= 1'b1;
                            state     <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (bus_rvalid) begin
                        state <= IDLE;
                        if (owner_ls) begin
                            ls_rvalid <= 1'b1;
                            ls_err    <= 1'b0;
                            ls_rdata  <= bus_we ? 32'd0 : ld_data;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= bus_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a scripted bus responder plus a response scoreboard.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic [31:0] ls_addr;
    logic        ls_we;
    logic [1:0]  ls_sz;
    logic        ls_sx;
    logic [31:0] ls_wdata;
    logic        ls_ready;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_sz(ls_sz),
        .ls_sx(ls_sx), .ls_wdata(ls_wdata), .ls_ready(ls_ready),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_ls;
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] exp_rd;
        logic        err;
    } ls_vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ls_vec_t tbl[12] = '{
        '{32'h203, 1'b0, 2'd0, 1'b1, 32'h0,        32'h80FF1234, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0},
        '{32'h203, 1'b0, 2'd0, 1'b0, 32'h0,        32'h80FF1234, 4'b1000, 32'h0,        32'h00000080, 1'b0},
        '{32'h102, 1'b1, 2'd1, 1'b0, 32'h0000ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0,        1'b0},
        '{32'h100, 1'b0, 2'd1, 1'b1, 32'h0,        32'h12348765, 4'b0011, 32'h0,        32'hFFFF8765, 1'b0},
        '{32'h102, 1'b0, 2'd1, 1'b0, 32'h0,        32'h9ABC0000, 4'b1100, 32'h0,        32'h00009ABC, 1'b0},
        '{32'h201, 1'b0, 2'd0, 1'b1, 32'h0,        32'h00007F00, 4'b0010, 32'h0,        32'h0000007F, 1'b0},
        '{32'h002, 1'b1, 2'd0, 1'b0, 32'h123456A5, 32'h0,        4'b0100, 32'hA5A5A5A5, 32'h0,        1'b0},
        '{32'h010, 1'b0, 2'd2, 1'b1, 32'h0,        32'h87654321, 4'b1111, 32'h0,        32'h87654321, 1'b0},
        '{32'h014, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0,        1'b0},
        '{32'h101, 1'b0, 2'd2, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1},
        '{32'h100, 1'b0, 2'd3, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1},
        '{32'h103, 1'b1, 2'd1, 1'b0, 32'h0000BEEF, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1}
    };

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the port's ready, lets the accept edge pass, returns inside cycle 1.
    task automatic wait_ready(input logic is_ls, output int waited);
        waited = 0;
        #1;
        while (!(is_ls ? ls_ready : if_ready) && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (waited >= 20) chk("ready_timeout", 32'(waited), 32'd0);
        tick();
    endtask

    task automatic bus_serve(input logic [31:0] addr, input logic [3:0] be, input logic we,
                             input logic [31:0] wdata, input logic chk_wd, input logic [31:0] rdata,
                             input int gnt_delay, input logic stray_rv);
        int w = 0;
        while (!bus_req && w < 10) begin
            tick();
            w++;
        end
        chk("bus_req_latency", 32'(w), 32'd0);
        chk("bus_addr", bus_addr, addr);
        chk("bus_be", 32'(bus_be), 32'(be));
        chk("bus_we", 32'(bus_we), 32'(we));
        if (chk_wd) chk("bus_wdata", bus_wdata, wdata);
        repeat (gnt_delay) begin
            bus_rvalid = stray_rv;
            bus_rdata  = 32'hBAD0BAD0;
            tick();
            chk("bus_req_hold", 32'(bus_req), 32'd1);
            chk("bus_addr_hold", bus_addr, addr);
        end
        bus_rvalid = 1'b0;
        bus_gnt    = 1'b1;
        tick();
        bus_gnt    = 1'b0;
        chk("bus_req_drop", 32'(bus_req), 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = $urandom;
        chk("rvalid_latency", 32'(if_rvalid | ls_rvalid), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && (if_rvalid || ls_rvalid)) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_owner", {30'd0, if_rvalid, ls_rvalid}, {30'd0, !e.is_ls, e.is_ls});
                if (e.is_ls) begin
                    chk("ls_rdata", ls_rdata, e.data);
                    chk("ls_err", 32'(ls_err), 32'(e.err));
                end else begin
                    chk("if_rdata", if_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int    w;
        string gseq;
        logic  exp_ls;
        logic [31:0] rd;

        rst = 1'b1; if_req = 1'b1; if_addr = 32'h44;
        ls_req = 1'b0; ls_addr = '0; ls_we = 1'b0; ls_sz = 2'd0; ls_sx = 1'b0; ls_wdata = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) tick();
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_rvalids", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_ls_err", 32'(ls_err), 32'd0);
        rst = 1'b0; if_req = 1'b0;
        tick();

        // Fetch, zero-wait bus
        if_addr = 32'h1003; if_req = 1'b1;
        wait_ready(1'b0, w);
        if_req = 1'b0;
        chk("if_accept_wait", 32'(w), 32'd0);
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        bus_serve(32'h1000, 4'b1111, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 0, 1'b0);

        // Fetch with grant delay and a stray bus_rvalid during ADDR
        if_addr = 32'h2000_000A; if_req = 1'b1;
        wait_ready(1'b0, w);
        if_req = 1'b0;
        sb.push_back('{1'b0, 32'h01234567, 1'b0});
        bus_serve(32'h2000_0008, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h01234567, 2, 1'b1);

        foreach (tbl[i]) begin
            ls_addr = tbl[i].addr; ls_we = tbl[i].we; ls_sz = tbl[i].sz;
            ls_sx = tbl[i].sx; ls_wdata = tbl[i].wdata; ls_req = 1'b1;
            wait_ready(1'b1, w);
            ls_req = 1'b0;
            sb.push_back('{1'b1, tbl[i].exp_rd, tbl[i].err});
            if (tbl[i].err) begin
                chk("err_no_bus_req", 32'(bus_req), 32'd0);
                chk("err_rvalid_next", 32'(ls_rvalid), 32'd1);
                if_req = 1'b1;
                #1;
                chk("err_cycle_no_accept", 32'(if_ready), 32'd0);
                if_req = 1'b0;
                tick();
                chk("err_bus_idle", 32'(bus_req), 32'd0);
            end else begin
                bus_serve(tbl[i].addr & 32'hFFFF_FFFC, tbl[i].be, tbl[i].we, tbl[i].bwd,
                          tbl[i].we, tbl[i].rdata, i % 2, 1'b0);
            end
        end
        chk("if_rdata_hold", if_rdata, 32'h01234567);
        tick();

        // Starvation guard: both ports requesting continuously
        gseq = "LLLLFLLLLF";
        if_addr = 32'h40; ls_addr = 32'h80; ls_we = 1'b0; ls_sz = 2'd2; ls_sx = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        for (int k = 0; k < gseq.len(); k++) begin
            exp_ls = (gseq[k] == "L");
            rd = 32'hA000_0000 + 32'(k);
            w = 0;
            #1;
            while (!(if_ready || ls_ready) && w < 20) begin
                @(posedge clk);
                #2;
                w++;
            end
            chk("starve_grant_is_ls", 32'(ls_ready), 32'(exp_ls));
            if (k > 0) chk("b2b_accept_wait", 32'(w), 32'd0);
            sb.push_back('{exp_ls, rd, 1'b0});
            tick();
            bus_serve(exp_ls ? 32'h80 : 32'h40, 4'b1111, 1'b0, 32'h0, 1'b0, rd, 0, 1'b0);
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick();

        // Reset while waiting for a grant
        if_addr = 32'h3000; if_req = 1'b1;
        wait_ready(1'b0, w);
        if_req = 1'b0;
        chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
        rst = 1'b0;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        chk("rst_gnt_ignored", 32'(bus_req), 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'h0BAD0BAD;
        tick();
        bus_rvalid = 1'b0;
        repeat (3) begin
            chk("rst_no_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
            tick();
        end
        chk("rst_if_rdata_clear", if_rdata, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
